counter_core: RTL
=================

# counter_core

Synthesizable configurable up/down counter that is the design under test driven by the counter simulation top. It takes that top's `clock` and `reset`, and exposes the count value and a one-cycle terminal-count pulse. It also reports boundary events through a one-entry valid/ready record buffer that the bench monitor drains.

## Interface
- `WIDTH`, default 8: counter width in bits.
- `LIMIT`, default 2**WIDTH-1: terminal value. Count range is 0..LIMIT inclusive. Must satisfy 1 <= LIMIT <= 2**WIDTH-1.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `en`  in  1: step enable.
- `up`  in  1: direction; 1 = increment, 0 = decrement.
- `load`  in  1: synchronous load request.
- `load_val`  in  WIDTH: value to load.
- `sat`  in  1: 1 = saturate at boundary, 0 = wrap (see Configuration).
- `count`  out  WIDTH: current count.
- `tc`  out  1: one-cycle boundary-event pulse.
- `evt_valid`  out  1: event record available.
- `evt_ready`  in  1: consumer accepts record.
- `evt_data`  out  9: {dir, seq[7:0]}.
- `drop`  out  1: sticky flag, set when an event record was lost.

## Operation
- Reset (`reset`=0, asynchronous): `count`=0, `tc`=0, `evt_valid`=0, `evt_data`=0, `drop`=0, internal `seq`=0. Asserting reset mid-operation discards any pending record immediately.
- Priority per cycle: `load` > `en` > hold.
- Load: `count` <= min(`load_val`, `LIMIT`). A load never generates an event, even if `en` is also high.
- Step up: if `count` < `LIMIT` then `count`+1, else boundary event.
- Step down: if `count` > 0 then `count`-1, else boundary event.
- Boundary event:
  - Wrap mode: `count` -> 0 going up, `LIMIT` going down.
  - Saturate mode: `count` holds.
  - In both modes an event pulses `tc`, increments `seq` (mod 256, wraps 255->0) and produces record {`up`, new `seq`}.
- Record buffer is one entry:
  - Empty + event: load record, `evt_valid`=1.
  - Full + `evt_ready`=1 + event in the same cycle: the new record replaces the old one and `evt_valid` stays 1. No drop.
  - Full + `evt_ready`=0 + event: keep the old record, set `drop`=1. `seq` still increments.
  - Full + `evt_ready`=1 + no event: `evt_valid`=0.
- `evt_data` is stable while `evt_valid`=1 and `evt_ready`=0.
- `drop` clears only on reset.
- `evt_ready` is ignored while `evt_valid`=0.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- `count` reflects a step or load one edge after the inputs are sampled.
- `tc` is high for exactly the cycle following the edge at which the event occurred, i.e. together with the updated `count`.
- Consecutive events (`en` held at the boundary in saturate mode) keep `tc` high every cycle.
- A record appears on `evt_valid`/`evt_data` on the same edge as `tc`. Latency from event to record is 1 cycle.
- A handshake completes on the rising edge where `evt_valid`=1 and `evt_ready`=1.
- Sustained throughput is one record per cycle when `evt_ready` is held at 1.

## Configuration
- `COUNTER_SAT_EN`
  - Defined: the `sat` input is honoured as described above.
  - Undefined: saturate logic is compiled out, the `sat` port remains but is ignored, and the counter always wraps. Event, `tc` and record behaviour are unchanged.

## Test plan
All scenarios use `WIDTH`=4, `LIMIT`=9.
- Reset then `en`=1, `up`=1 for 12 cycles -> `count` 1..9, 0, 1, 2. `tc`=1 only in the cycle showing 0. Record {1, 0x01}.
- `load`=1, `load_val`=15 -> `count`=9, no `tc`. Then `en`=1, `up`=0 from 1 -> 0, then 9 with `tc`=1 and record {0, seq}.
- `COUNTER_SAT_EN` defined, `sat`=1, `up`=1 at 9 for 3 cycles -> `count` stays 9, `tc` high 3 cycles, `seq` +3. With the macro undefined, the same stimulus wraps to 0.
- `evt_ready`=0, two events -> first record held stable, `drop`=1, `seq` +2. Then `evt_ready`=1 -> `evt_valid`=0 next cycle. `drop` stays 1 until reset.
- Buffer full, `evt_ready`=1 and event in the same cycle -> `evt_valid` stays 1, `evt_data` shows the new `seq`, `drop`=0.
- Assert `reset` low asynchronously mid-count with a record pending -> all outputs 0 before the next clock edge. After release, counting restarts from 0.

Source files
------------

// File: rtl/counter_core.sv
// Configurable up/down counter with boundary-event pulse and a one-entry record buffer.
// Build macro COUNTER_SAT_EN enables saturate mode via the sat input; otherwise the counter always wraps.
module counter_core #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = (2**WIDTH) - 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [8:0]       evt_data,
  output logic             drop
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             evt_valid_q, evt_valid_d;
  logic [8:0]       evt_data_q, evt_data_d;
  logic             drop_q, drop_d;
  logic [7:0]       seq_q, seq_d;
  logic             sat_on;
  logic             boundary;

`ifdef COUNTER_SAT_EN
  assign sat_on = sat;
`else
  logic unused_sat;
  assign unused_sat = sat;
  assign sat_on     = 1'b0;
`endif

  always_comb begin
    count_d     = count_q;
    tc_d        = 1'b0;
    seq_d       = seq_q;
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    drop_d      = drop_q;
    boundary    = 1'b0;

    if (load) begin
      count_d = (load_val > LIM) ? LIM : load_val;
    end else if (en) begin
      if (up) begin
        if (count_q < LIM) count_d = count_q + ONE;
        else begin
          boundary = 1'b1;
          count_d  = sat_on ? count_q : '0;
        end
      end else begin
        if (count_q != '0) count_d = count_q - ONE;
        else begin
          boundary = 1'b1;
          count_d  = sat_on ? count_q : LIM;
        end
      end
    end

    // A consumer accepting in the same cycle as a new event frees the slot for it.
    if (boundary) begin
      tc_d  = 1'b1;
      seq_d = seq_q + 8'd1;
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_data_d  = {up, seq_d};
      end else begin
        drop_d = 1'b1;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      tc_q        <= 1'b0;
      seq_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      tc_q        <= tc_d;
      seq_q       <= seq_d;
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      drop_q      <= drop_d;
    end
  end

  assign count     = count_q;
  assign tc        = tc_q;
  assign evt_valid = evt_valid_q;
  assign evt_data  = evt_data_q;
  assign drop      = drop_q;

endmodule
